axi_llc_ax_sched: RTL and testbench
===================================

// Module: axi_llc_ax_sched
// PURPOSE
// Descriptor scheduler in front of one axi_llc_ax_master instance (evict or refill side).
// - Arbitrates round-robin between two descriptor sources: port 0 miss pipeline, port 1 flush unit.
// - Registers the winner and forwards it to the AX master.
// - Throttles forwarding with an outstanding-burst credit counter. The counter is released by
//   response completion (B handshake for evict, R last for refill).
// - Provides a drain handshake used before reconfiguration / flush end.
// PARAMETERS
// desc_t         logic                  LLC descriptor type (fields evict, refill used)
// cache_unit     axi_llc_pkg::EvictUnit selects flag: EvictUnit->desc.evict, RefilUnit->desc.refill
// MaxOutstanding 4                      max flagged bursts in flight, range 1..255
// CntWidth       $clog2(MaxOutstanding+1) derived, width of cnt_o
// PORTS
// clk_i          in  1        clock, all logic on rising edge
// rst_ni         in  1        synchronous reset, active low
// desc_i         in  2*desc_t requester descriptors, [0] miss, [1] flush
// desc_valid_i   in  2        requester valid
// desc_ready_o   out 2        requester ready
// desc_o         out desc_t   descriptor to AX master
// desc_valid_o   out 1        descriptor valid
// desc_ready_i   in  1        AX master ready
// rsp_done_i     in  1        one completed burst (pulse, may assert every cycle)
// drain_req_i    in  1        stop accepting and wait for all bursts to complete
// drain_done_o   out 1        high while in DRAINED
// cnt_o          out CntWidth current outstanding flagged bursts
// BEHAVIOUR
// Reset (rst_ni low at a clock edge):
// - desc_valid_o=0, desc_o='0, cnt_o=0, drain_done_o=0, priority pointer=0, state IDLE.
// - Reset during a held descriptor drops it, with no error.
// FSM states: IDLE, HOLD, DRAIN, DRAINED.
// - IDLE: desc_ready_o[i] = grant[i] & credit_ok(i) & ~drain_req_i.
//   - grant: the only valid port, else port == pointer.
//   - credit_ok(i) = ~flag(desc_i[i]) | (cnt_o < MaxOutstanding).
//   - On accept: register descriptor, desc_valid_o=1 next cycle, ->HOLD, pointer = ~granted port.
//   - On accept with flag set: cnt += 1.
//   - The counter is reserved at accept, never at the downstream handshake.
//   - If the granted port lacks credit: no accept; the other port is NOT granted that cycle.
//   - drain_req_i=1 -> DRAIN.
// - HOLD: desc_o/desc_valid_o stable until desc_ready_i.
//   - On handshake: ->IDLE, or ->DRAIN if drain_req_i.
//   - No back-to-back accept: throughput 1 per 2 cycles, latency accept->valid 1 cycle.
// - DRAIN: desc_ready_o=0. When cnt_o==0 -> DRAINED.
// - DRAINED: drain_done_o=1, desc_ready_o=0. drain_req_i=0 -> IDLE next cycle.
// Counter:
// - cnt_next = cnt + inc - dec. Simultaneous inc and dec leave the count unchanged.
// - rsp_done_i with cnt==0 leaves cnt at 0 and fires an assertion (sim only).
// - inc never occurs when cnt==MaxOutstanding (guaranteed by credit_ok).
// - Unflagged descriptors pass without touching cnt.
// rsp_done_i is counted in every state, including DRAIN/DRAINED.
// CONFIGURATION
// AXI_LLC_AX_SCHED_STATS_EN defined:
// - adds outputs stall_credit_o[31:0] and stall_down_o[31:0].
//   - stall_credit_o: cycles a granted valid port was refused for credit.
//   - stall_down_o: HOLD cycles with desc_ready_i=0.
// - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
// Not defined: ports and counters absent; identical functional timing.
// TESTING
// 1. Reset, port0 valid flag=1, ready_i=1 -> valid_o cycle 2, cnt_o=1; rsp_done pulse -> cnt_o=0.
// 2. Both ports valid continuously, ready_i=1 -> grants alternate 0,1,0,1; 8 descriptors in 16 cycles.
// 3. MaxOutstanding=4, 5 flagged descs, no rsp_done -> 4 forwarded, ready_o stays 0;
//    1 rsp_done -> 5th accepted.
// 4. cnt=4, same-cycle accept blocked, rsp_done and flagged desc -> next cycle accept, cnt stays 4.
// 5. cnt=2, drain_req_i=1 -> ready_o=0; 2 rsp_done -> drain_done_o=1 one cycle after cnt=0;
//    drain_req_i=0 -> IDLE.
// 6. HOLD with ready_i=0, rst_ni low 1 cycle -> valid_o=0, cnt_o=0 next edge; STATS counters=0.

Source files
------------

// File: rtl/axi_llc_ax_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : axi_llc_ax_sched                                              |
// | Description: Round-robin descriptor scheduler with outstanding-burst       |
// |              credit throttling and drain handshake for one AX master.      |
// |              Optional stall statistics: AXI_LLC_AX_SCHED_STATS_EN          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module axi_llc_ax_sched #(
    parameter int DESC_WIDTH      = 8,
    parameter int EVICT_BIT       = 0,
    parameter int REFILL_BIT      = 1,
    parameter int CACHE_UNIT      = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [2*DESC_WIDTH-1:0] desc_i,
    input  logic [1:0]              desc_valid_i,
    output logic [1:0]              desc_ready_o,
    output logic [DESC_WIDTH-1:0]   desc_o,
    output logic                    desc_valid_o,
    input  logic                    desc_ready_i,
    input  logic                    rsp_done_i,
    input  logic                    drain_req_i,
    output logic                    drain_done_o,
    output logic [CNT_WIDTH-1:0]    cnt_o
`ifdef AXI_LLC_AX_SCHED_STATS_EN
    ,
    output logic [31:0]             stall_credit_o,
    output logic [31:0]             stall_down_o
`endif
);

    localparam int c_EVICT_UNIT = 0;
    localparam int c_FLAG_BIT   = (CACHE_UNIT == c_EVICT_UNIT) ? EVICT_BIT : REFILL_BIT;
    localparam logic [CNT_WIDTH-1:0] c_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DRAINED = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_ptr;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [DESC_WIDTH-1:0]   r_desc;
    logic                    r_valid;
    logic                    r_drain_done;

    logic [DESC_WIDTH-1:0]   w_desc0;
    logic [DESC_WIDTH-1:0]   w_desc1;
    logic [DESC_WIDTH-1:0]   w_gdesc;
    logic                    w_grant;
    logic                    w_flag;
    logic                    w_credit_ok;
    logic                    w_can_accept;
    logic                    w_accept;
    logic                    w_inc;
    logic                    w_dec;

    assign w_desc0 = desc_i[DESC_WIDTH-1:0];
    assign w_desc1 = desc_i[2*DESC_WIDTH-1:DESC_WIDTH];

    // A lone valid port wins outright; a tie goes to the pointer. The loser is
    // never granted in the same cycle, even if the winner lacks credit.
    assign w_grant      = (desc_valid_i[0] ^ desc_valid_i[1]) ? desc_valid_i[1] : r_ptr;
    assign w_gdesc      = w_grant ? w_desc1 : w_desc0;
    assign w_flag       = w_gdesc[c_FLAG_BIT];
    assign w_credit_ok  = ~w_flag | (r_cnt < c_MAX);
    assign w_can_accept = (r_state == ST_IDLE) & w_credit_ok & ~drain_req_i;
    assign desc_ready_o = w_can_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept     = |(desc_ready_o & desc_valid_i);
    assign w_inc        = w_accept & w_flag;
    assign w_dec        = rsp_done_i & (r_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_cnt        <= '0;
            r_desc       <= '0;
            r_valid      <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + c_ONE;
            end else if (!w_inc && w_dec) begin
                r_cnt <= r_cnt - c_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (drain_req_i) begin
                        r_state <= ST_DRAIN;
                    end else if (w_accept) begin
                        r_desc  <= w_gdesc;
                        r_valid <= 1'b1;
                        r_ptr   <= ~w_grant;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (desc_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= drain_req_i ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_drain_done <= 1'b1;
                        r_state      <= ST_DRAINED;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req_i) begin
                        r_drain_done <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign desc_o       = r_desc;
    assign desc_valid_o = r_valid;
    assign drain_done_o = r_drain_done;
    assign cnt_o        = r_cnt;

`ifdef AXI_LLC_AX_SCHED_STATS_EN
    logic [31:0] r_stall_credit;
    logic [31:0] r_stall_down;
    logic        w_stall_credit;
    logic        w_stall_down;

    assign w_stall_credit = (r_state == ST_IDLE) & desc_valid_i[w_grant] & ~w_credit_ok & ~drain_req_i;
    assign w_stall_down   = (r_state == ST_HOLD) & ~desc_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_credit <= '0;
            r_stall_down   <= '0;
        end else begin
            if (w_stall_credit && (r_stall_credit != 32'hFFFF_FFFF)) begin
                r_stall_credit <= r_stall_credit + 32'd1;
            end
            if (w_stall_down && (r_stall_down != 32'hFFFF_FFFF)) begin
                r_stall_down <= r_stall_down + 32'd1;
            end
        end
    end

    assign stall_credit_o = r_stall_credit;
    assign stall_down_o   = r_stall_down;
`endif

    // A completion with nothing outstanding indicates an upstream protocol error.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_done_i && (r_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_ax_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_axi_llc_ax_sched                                           |
// | Description: Directed vector bench for axi_llc_ax_sched (evict unit, 4 cr). |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_axi_llc_ax_sched;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] desc_i;
    logic [1:0]  desc_valid_i;
    logic [1:0]  desc_ready_o;
    logic [7:0]  desc_o;
    logic        desc_valid_o;
    logic        desc_ready_i;
    logic        rsp_done_i;
    logic        drain_req_i;
    logic        drain_done_o;
    logic [2:0]  cnt_o;
`ifdef AXI_LLC_AX_SCHED_STATS_EN
    logic [31:0] stall_credit_o;
    logic [31:0] stall_down_o;
`endif

    int total = 0;
    int bad   = 0;
    int row   = 0;

    always #5 clk = ~clk;

    axi_llc_ax_sched #(
        .DESC_WIDTH      (8),
        .EVICT_BIT       (0),
        .REFILL_BIT      (1),
        .CACHE_UNIT      (0),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .desc_i         (desc_i),
        .desc_valid_i   (desc_valid_i),
        .desc_ready_o   (desc_ready_o),
        .desc_o         (desc_o),
        .desc_valid_o   (desc_valid_o),
        .desc_ready_i   (desc_ready_i),
        .rsp_done_i     (rsp_done_i),
        .drain_req_i    (drain_req_i),
        .drain_done_o   (drain_done_o),
        .cnt_o          (cnt_o)
`ifdef AXI_LLC_AX_SCHED_STATS_EN
        ,
        .stall_credit_o (stall_credit_o),
        .stall_down_o   (stall_down_o)
`endif
    );

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       rsp;
        logic       drn;
        logic [1:0] e_rdy;
        logic       e_vld;
        logic [7:0] e_desc;
        logic [2:0] e_cnt;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (row %0d): got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic rdy, input logic rsp, input logic drn);
        desc_valid_i = v;
        desc_i       = {d1, d0};
        desc_ready_i = rdy;
        rsp_done_i   = rsp;
        drain_req_i  = drn;
    endtask

    initial begin
        // Each row: inputs for this cycle, then expected ready (comb) and the
        // registered outputs visible before the clock edge.
        //             v      d0     d1    rdy   rsp   drn   e_rdy  vld   desc   cnt   done
        tbl.push_back('{2'b01,8'hA1,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'h00,3'd0,1'b0});
        tbl.push_back('{2'b00,8'hA1,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hA1,3'd1,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b1,1'b0, 2'b10,1'b0,8'hA1,3'd1,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b10,1'b0,8'hA1,3'd0,1'b0});
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b0,1'b0,1'b0, 2'b01,1'b0,8'hA1,3'd0,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b0,1'b0,1'b0, 2'b00,1'b1,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b10,8'h00,8'hC3,1'b0,1'b0,1'b0, 2'b00,1'b1,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b10,8'h00,8'hC3,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b10,8'h00,8'hC3,1'b1,1'b0,1'b0, 2'b10,1'b0,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hC3,3'd1,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b1,1'b0, 2'b01,1'b0,8'hC3,3'd1,1'b0});
        // credit exhaustion with four flagged bursts
        tbl.push_back('{2'b01,8'hA5,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'hC3,3'd0,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hA5,3'd1,1'b0});
        tbl.push_back('{2'b01,8'hA7,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'hA5,3'd1,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hA7,3'd2,1'b0});
        tbl.push_back('{2'b01,8'hA9,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'hA7,3'd2,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hA9,3'd3,1'b0});
        tbl.push_back('{2'b10,8'h00,8'hCB,1'b1,1'b0,1'b0, 2'b10,1'b0,8'hA9,3'd3,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hCB,3'd4,1'b0});
        tbl.push_back('{2'b11,8'hAD,8'hC4,1'b1,1'b0,1'b0, 2'b00,1'b0,8'hCB,3'd4,1'b0});
        tbl.push_back('{2'b01,8'hAD,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b0,8'hCB,3'd4,1'b0});
        tbl.push_back('{2'b01,8'hAD,8'h00,1'b1,1'b1,1'b0, 2'b00,1'b0,8'hCB,3'd4,1'b0});
        tbl.push_back('{2'b01,8'hAD,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'hCB,3'd3,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hAD,3'd4,1'b0});
        // simultaneous inc and dec
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b1,1'b0, 2'b10,1'b0,8'hAD,3'd4,1'b0});
        tbl.push_back('{2'b01,8'hAF,8'h00,1'b1,1'b1,1'b0, 2'b01,1'b0,8'hAD,3'd3,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b1,8'hAF,3'd3,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b1,1'b0, 2'b10,1'b0,8'hAF,3'd3,1'b0});
        // drain with two bursts outstanding
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b1,1'b0,1'b1, 2'b00,1'b0,8'hAF,3'd2,1'b0});
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b1,1'b1,1'b1, 2'b00,1'b0,8'hAF,3'd2,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b1,1'b1, 2'b00,1'b0,8'hAF,3'd1,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b1, 2'b00,1'b0,8'hAF,3'd0,1'b0});
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b1,1'b0,1'b1, 2'b00,1'b0,8'hAF,3'd0,1'b1});
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b0,8'hAF,3'd0,1'b1});
        tbl.push_back('{2'b01,8'hB0,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,8'hAF,3'd0,1'b0});
        // drain request arriving during the downstream handshake
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b1, 2'b00,1'b1,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b1, 2'b00,1'b0,8'hB0,3'd0,1'b0});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b00,1'b0,8'hB0,3'd0,1'b1});
        tbl.push_back('{2'b00,8'h00,8'h00,1'b1,1'b0,1'b0, 2'b10,1'b0,8'hB0,3'd0,1'b0});

        rst_ni = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(desc_valid_o), 32'd0);
        chk("rst_desc",  32'(desc_o),       32'd0);
        chk("rst_cnt",   32'(cnt_o),        32'd0);
        chk("rst_done",  32'(drain_done_o), 32'd0);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            row = i;
            drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].rdy, tbl[i].rsp, tbl[i].drn);
            #1;
            chk("ready_o", 32'(desc_ready_o), 32'(tbl[i].e_rdy));
            chk("valid_o", 32'(desc_valid_o), 32'(tbl[i].e_vld));
            chk("desc_o",  32'(desc_o),       32'(tbl[i].e_desc));
            chk("cnt_o",   32'(cnt_o),        32'(tbl[i].e_cnt));
            chk("done_o",  32'(drain_done_o), 32'(tbl[i].e_done));
            @(negedge clk);
        end

`ifdef AXI_LLC_AX_SCHED_STATS_EN
        chk("stall_credit", stall_credit_o, 32'd3);
        chk("stall_down",   stall_down_o,   32'd2);
`endif

        // Both ports valid for 16 cycles: port 1 first, then strict alternation.
        begin
            logic exp_port;
            int   hs;
            row      = 100;
            exp_port = 1'b1;
            hs       = 0;
            drive(2'b11, 8'h50, 8'h62, 1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                #1;
                if (desc_valid_o) begin
                    chk("alt_desc", 32'(desc_o), exp_port ? 32'h62 : 32'h50);
                    exp_port = ~exp_port;
                    hs++;
                end
                @(negedge clk);
            end
            chk("alt_count", 32'(hs), 32'd8);
        end

        // Reset while a flagged descriptor is held downstream.
        row = 200;
        drive(2'b01, 8'hA3, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hold_valid", 32'(desc_valid_o), 32'd1);
        chk("hold_desc",  32'(desc_o),       32'hA3);
        chk("hold_cnt",   32'(cnt_o),        32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        drive(2'b11, 8'h50, 8'h62, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst2_valid", 32'(desc_valid_o), 32'd0);
        chk("rst2_desc",  32'(desc_o),       32'd0);
        chk("rst2_cnt",   32'(cnt_o),        32'd0);
        chk("rst2_ptr",   32'(desc_ready_o), 32'b01);
`ifdef AXI_LLC_AX_SCHED_STATS_EN
        chk("rst2_stall_credit", stall_credit_o, 32'd0);
        chk("rst2_stall_down",   stall_down_o,   32'd0);
`endif
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
